pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Tracks registers with pending long-latency writes
//  (loads, multi-cycle ALU ops) in a scoreboard and stalls ID when its read ports hit one.
//  Sequences the multi-cycle EX unit and drives one stall vector shared by PC/IF/ID/EX/MEM/WB
//  pipeline registers. Owns flush sequencing for redirects and exceptions.
// PARAMETERS
//  NUM_REGS   32  architectural registers; r0 is never tracked
//  REG_AW     5   register address width, log2(NUM_REGS)
//  MC_CYCLES  4   EX occupancy of a multi-cycle op in cycles; legal range 2..15
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, synchronous, active-high
//  id_valid_i     in   1       ID holds a real (non-bubble) instruction
//  id_re1_i       in   1       ID read-port-1 enable (same as decoder re1)
//  id_raddr1_i    in   REG_AW  ID read-port-1 address
//  id_re2_i       in   1       ID read-port-2 enable
//  id_raddr2_i    in   REG_AW  ID read-port-2 address
//  id_we_i        in   1       ID instruction writes a register
//  id_waddr_i     in   REG_AW  ID destination register
//  id_long_i      in   1       ID instruction is long-latency (load or multi-cycle op)
//  ex_mc_start_i  in   1       one-cycle pulse: multi-cycle op entered EX
//  wb_we_i        in   1       WB writes regfile this cycle
//  wb_waddr_i     in   REG_AW  WB destination register
//  wb_long_i      in   1       WB write is from a long-latency instruction
//  flush_req_i    in   1       redirect/exception request
//  stall_o        out  6       [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold that register
//  flush_o        out  1       clear IF/ID/EX pipeline registers this cycle
//  mc_busy_o      out  1       multi-cycle unit occupied
//  mc_done_o      out  1       one-cycle pulse on final multi-cycle cycle
//  busy_vec_o     out  NUM_REGS scoreboard contents (bit0 always 0)
// BEHAVIOUR
//  Reset: scoreboard all 0, mc counter 0; stall_o=0, flush_o=0, mc_busy_o=0, mc_done_o=0.
//  Scoreboard (registered, one bit per reg):
//   - hazard = id_valid_i & ((id_re1_i & busy[raddr1] & raddr1!=0) | (id_re2_i & busy[raddr2] & raddr2!=0))
//   - set busy[id_waddr_i] when id_valid_i & id_we_i & id_long_i & waddr!=0 & ~stall_o[2] & ~flush
//   - clear busy[wb_waddr_i] when wb_we_i & wb_long_i
//   - set and clear same reg same cycle: set wins (newer producer). Clear of non-busy reg: no effect.
//   - no bypass: a reg cleared this cycle still reads busy for hazard -> release costs 1 stall cycle.
//  Multi-cycle counter (4 bit): ex_mc_start_i loads MC_CYCLES-1; decrements to 0 each cycle;
//   mc_busy_o = (cnt!=0); mc_done_o = (cnt==1). Start while busy: ignored (cannot occur legally).
//  Stall priority (combinational from state + inputs, zero latency):
//   1. flush_req_i          -> stall_o=6'b000000, flush_o=1
//   2. mc_busy_o            -> stall_o=6'b001111 (PC..EX held, bubble into MEM)
//   3. hazard               -> stall_o=6'b000111 (PC..ID held, bubble into EX)
//   4. else                 -> stall_o=0
//  Flush: on the flush cycle scoreboard cleared to 0 (same-cycle WB clears/ID sets ignored),
//   mc counter forced to 0, ex_mc_start_i ignored. flush_o is 1 exactly while flush_req_i is 1.
//  rst dominates everything incl. flush_req_i; reset mid multi-cycle op drops it silently.
// STRUCTURE
//  define.vh: `StallBus 5:0, stall encodings `STALL_NONE/`STALL_ID/`STALL_EX, `RegAddrBus reuse.
//  Sub-module reg_scoreboard: busy vector with set/clear/clear-all ports + two combinational
//   lookup ports. Counter, priority mux and flush logic stay in pipe_ctrl.
// TESTING
//  1 ld r3 issued, next instr reads r3 -> stall_o=6'b000111 until cycle after WB of r3, then 0
//  2 ex_mc_start_i with MC_CYCLES=4 -> stall_o=6'b001111 for 3 cycles, mc_done_o on 3rd, then 0
//  3 ID sets r5 while WB clears r5 same cycle -> busy_vec_o[5]=1 afterwards
//  4 id_raddr1=0, busy r0 attempt (long write to r0) -> busy_vec_o[0]=0, no stall ever
//  5 flush_req_i during mc op with r2,r7 busy -> flush_o=1, stall_o=0, busy_vec_o=0, mc_busy_o=0 next
//  6 rst asserted mid-hazard stall -> next cycle all outputs 0, scoreboard empty

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Stall encodings, stall-source enum and the source-to-vector map.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int MC_W    = 4;

  typedef logic [STALL_W-1:0] stall_t;

  // Bit order: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_FLUSH,
    SRC_MC,
    SRC_HAZ
  } stall_src_e;

  function automatic stall_t stall_vec(
    input stall_src_e src
  );
    stall_t v;
    v = STALL_NONE;
    unique case (src)
      SRC_MC:  v = STALL_EX;
      SRC_HAZ: v = STALL_ID;
      default: v = STALL_NONE;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports: set/clear/clear-all updates, two combinational lookups, full vector.
module pipe_ctrl_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_i,
  input  logic [REG_AW-1:0]   set_addr_i,
  input  logic                clr_i,
  input  logic [REG_AW-1:0]   clr_addr_i,
  input  logic                clr_all_i,
  input  logic [REG_AW-1:0]   raddr1_i,
  input  logic [REG_AW-1:0]   raddr2_i,
  output logic                busy1_o,
  output logic                busy2_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a new producer wins over
  // the retiring one; clear-all overrides both.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
    if (clr_all_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy1_o    = busy_q[raddr1_i];
  assign busy2_o    = busy_q[raddr2_i];
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: scoreboard hazards, multi-cycle EX, flush.
// Ports: ID read/write info, EX mc start, WB write, flush in; stall/flush/mc status out.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int MC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid_i,
  input  logic                id_re1_i,
  input  logic [REG_AW-1:0]   id_raddr1_i,
  input  logic                id_re2_i,
  input  logic [REG_AW-1:0]   id_raddr2_i,
  input  logic                id_we_i,
  input  logic [REG_AW-1:0]   id_waddr_i,
  input  logic                id_long_i,
  input  logic                ex_mc_start_i,
  input  logic                wb_we_i,
  input  logic [REG_AW-1:0]   wb_waddr_i,
  input  logic                wb_long_i,
  input  logic                flush_req_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic                mc_busy_o,
  output logic                mc_done_o,
  output logic [NUM_REGS-1:0] busy_vec_o
);

  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_CYCLES - 1);

  logic            busy1, busy2;
  logic            hazard, set_en, clr_en;
  logic [MC_W-1:0] cnt_q, cnt_d;
  stall_src_e      src;

  pipe_ctrl_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (set_en),
    .set_addr_i (id_waddr_i),
    .clr_i      (clr_en),
    .clr_addr_i (wb_waddr_i),
    .clr_all_i  (flush_req_i),
    .raddr1_i   (id_raddr1_i),
    .raddr2_i   (id_raddr2_i),
    .busy1_o    (busy1),
    .busy2_o    (busy2),
    .busy_vec_o (busy_vec_o)
  );

  // No WB->ID bypass: a register cleared this cycle
  // still reads busy, costing one extra stall cycle.
  assign hazard = id_valid_i
    & ((id_re1_i & busy1 & (id_raddr1_i != '0))
     | (id_re2_i & busy2 & (id_raddr2_i != '0)));

  assign mc_busy_o = (cnt_q != '0);
  assign mc_done_o = (cnt_q == MC_W'(1));

  always_comb begin
    src = SRC_NONE;
    priority case (1'b1)
      flush_req_i: src = SRC_FLUSH;
      mc_busy_o:   src = SRC_MC;
      hazard:      src = SRC_HAZ;
      default:     src = SRC_NONE;
    endcase
  end

  assign stall_o = stall_vec(src);
  assign flush_o = flush_req_i;

  // Only an instruction actually leaving ID may claim its
  // destination; a held or flushed one would set it twice.
  assign set_en = id_valid_i & id_we_i & id_long_i
    & (id_waddr_i != '0) & ~stall_o[2] & ~flush_req_i;
  assign clr_en = wb_we_i & wb_long_i;

  // Start while busy cannot happen legally; it is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_req_i)        cnt_d = '0;
    else if (cnt_q != '0)   cnt_d = cnt_q - MC_W'(1);
    else if (ex_mc_start_i) cnt_d = MC_LOAD;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus reset sequences.
// Inputs driven on negedge, outputs compared 1ns later.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, id_re1_i, id_re2_i;
  logic [4:0]  id_raddr1_i, id_raddr2_i;
  logic        id_we_i, id_long_i;
  logic [4:0]  id_waddr_i;
  logic        ex_mc_start_i;
  logic        wb_we_i, wb_long_i;
  logic [4:0]  wb_waddr_i;
  logic        flush_req_i;
  logic [5:0]  stall_o;
  logic        flush_o, mc_busy_o, mc_done_o;
  logic [31:0] busy_vec_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .NUM_REGS  (32),
    .REG_AW    (5),
    .MC_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid_i    (id_valid_i),
    .id_re1_i      (id_re1_i),
    .id_raddr1_i   (id_raddr1_i),
    .id_re2_i      (id_re2_i),
    .id_raddr2_i   (id_raddr2_i),
    .id_we_i       (id_we_i),
    .id_waddr_i    (id_waddr_i),
    .id_long_i     (id_long_i),
    .ex_mc_start_i (ex_mc_start_i),
    .wb_we_i       (wb_we_i),
    .wb_waddr_i    (wb_waddr_i),
    .wb_long_i     (wb_long_i),
    .flush_req_i   (flush_req_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mc_busy_o     (mc_busy_o),
    .mc_done_o     (mc_done_o),
    .busy_vec_o    (busy_vec_o)
  );

  typedef struct {
    logic        v, re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic        we;
    logic [4:0]  wa;
    logic        lng, mcs, wbwe;
    logic [4:0]  wbwa;
    logic        wbl, fl;
    logic [5:0]  e_stall;
    logic        e_flush, e_busy, e_done;
    logic [31:0] e_vec;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;

  task automatic add(
    input logic v, input logic re1, input logic [4:0] ra1,
    input logic re2, input logic [4:0] ra2,
    input logic we, input logic [4:0] wa, input logic lng,
    input logic mcs, input logic wbwe, input logic [4:0] wbwa,
    input logic wbl, input logic fl,
    input logic [5:0] es, input logic ef, input logic eb,
    input logic ed, input logic [31:0] ev
  );
    vec_t t;
    t = '{v, re1, ra1, re2, ra2, we, wa, lng, mcs, wbwe, wbwa,
          wbl, fl, es, ef, eb, ed, ev};
    tbl.push_back(t);
  endtask

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    id_valid_i    = t.v;
    id_re1_i      = t.re1;
    id_raddr1_i   = t.ra1;
    id_re2_i      = t.re2;
    id_raddr2_i   = t.ra2;
    id_we_i       = t.we;
    id_waddr_i    = t.wa;
    id_long_i     = t.lng;
    ex_mc_start_i = t.mcs;
    wb_we_i       = t.wbwe;
    wb_waddr_i    = t.wbwa;
    wb_long_i     = t.wbl;
    flush_req_i   = t.fl;
  endtask

  task automatic chk_all(
    input string nm, input logic [5:0] es, input logic ef,
    input logic eb, input logic ed, input logic [31:0] ev
  );
    chk({nm, ".stall"}, 32'(stall_o), 32'(es));
    chk({nm, ".flush"}, 32'(flush_o), 32'(ef));
    chk({nm, ".mcbusy"}, 32'(mc_busy_o), 32'(eb));
    chk({nm, ".mcdone"}, 32'(mc_done_o), 32'(ed));
    chk({nm, ".vec"}, busy_vec_o, ev);
  endtask

  vec_t idle;

  initial begin
    idle = '{0,0,0,0,0,0,0,0,0,0,0,0,0,S0,0,0,0,32'h0};
    // args: v re1 ra1 re2 ra2 we wa lng mcs wbwe wbwa wbl fl | stall flush busy done vec
    // load r3, then consumer stalls until cycle after WB
    add(1,1,1,0,0,1,3,1,0,0,0,0,0, S0,0,0,0,32'h0);
    add(1,1,3,0,0,0,0,0,0,0,0,0,0, SI,0,0,0,32'h8);
    add(1,1,3,0,0,0,0,0,0,0,0,0,0, SI,0,0,0,32'h8);
    add(1,1,3,0,0,0,0,0,0,1,3,1,0, SI,0,0,0,32'h8);
    add(1,1,3,0,0,0,0,0,0,0,0,0,0, S0,0,0,0,32'h0);
    // multi-cycle op, held ID long write must not set r9
    add(0,0,0,0,0,0,0,0,1,0,0,0,0, S0,0,0,0,32'h0);
    add(1,0,0,0,0,1,9,1,0,0,0,0,0, SE,0,1,0,32'h0);
    add(0,0,0,0,0,0,0,0,0,0,0,0,0, SE,0,1,0,32'h0);
    add(0,0,0,0,0,0,0,0,0,0,0,0,0, SE,0,1,1,32'h0);
    add(0,0,0,0,0,0,0,0,0,0,0,0,0, S0,0,0,0,32'h0);
    // set vs clear same reg; short WB and non-busy clear ignored
    add(1,0,0,0,0,1,5,1,0,0,0,0,0, S0,0,0,0,32'h0);
    add(1,0,0,0,0,1,5,1,0,1,5,1,0, S0,0,0,0,32'h20);
    add(0,0,0,0,0,0,0,0,0,1,5,0,0, S0,0,0,0,32'h20);
    add(0,0,0,0,0,0,0,0,0,1,6,1,0, S0,0,0,0,32'h20);
    add(0,0,0,0,0,0,0,0,0,1,5,1,0, S0,0,0,0,32'h20);
    // r0 is never tracked and never hazards
    add(1,1,0,1,0,1,0,1,0,0,0,0,0, S0,0,0,0,32'h0);
    add(1,1,0,1,0,0,0,0,0,0,0,0,0, S0,0,0,0,32'h0);
    // flush during mc op with r2,r7 busy
    add(1,0,0,0,0,1,2,1,0,0,0,0,0, S0,0,0,0,32'h0);
    add(1,0,0,0,0,1,7,1,0,0,0,0,0, S0,0,0,0,32'h4);
    add(0,0,0,0,0,0,0,0,1,0,0,0,0, S0,0,0,0,32'h84);
    add(1,1,7,0,0,0,0,0,0,0,0,0,0, SE,0,1,0,32'h84);
    add(1,1,7,0,0,1,9,1,1,1,2,1,1, S0,1,1,0,32'h84);
    add(1,1,7,1,2,0,0,0,0,0,0,0,0, S0,0,0,0,32'h0);

    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("reset", S0, 0, 0, 0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].e_stall, tbl[i].e_flush,
              tbl[i].e_busy, tbl[i].e_done, tbl[i].e_vec);
    end

    // reset in the middle of a hazard stall
    @(negedge clk);
    drive(idle);
    id_valid_i = 1; id_we_i = 1; id_waddr_i = 4; id_long_i = 1;
    @(negedge clk);
    drive(idle);
    id_valid_i = 1; id_re2_i = 1; id_raddr2_i = 4;
    #1;
    chk("rst6.pre", 32'(stall_o), 32'(SI));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("rst6.post", S0, 0, 0, 0, 32'h0);

    // reset during a multi-cycle op drops it
    @(negedge clk);
    drive(idle);
    ex_mc_start_i = 1;
    @(negedge clk);
    drive(idle);
    #1;
    chk("rstmc.pre", 32'(mc_busy_o), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("rstmc.post", S0, 0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
